dmem_arbiter: RTL and testbench

//  Shares the single-port 8x8 DATA_MEMORY between two requesters: the CPU load/store path (port c)
//  and a debug/DMA port (port d) driven from board switches/UART. Round-robin arbitration with
//  a valid/ready handshake, a registered memory command stage and a registered read-return stage.

---
 rtl/dmem_arbiter_pkg.sv | 13 +
 rtl/rr_arb2.sv | 29 ++
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and requester ids.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_CLEAR  = 2'd2
  } state_e;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, a conflict goes
// to the port that was not granted most recently.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  // Pick the winner and remember who got the grant when it is actually taken.
  always_comb begin
    gnt    = req;
    last_d = last_q;
    if (req == 2'b11) gnt = (last_q == PORT_D) ? 2'b01 : 2'b10;
    if (advance && (|req)) last_d = gnt[1];
  end

  // Pointer starts at d so the CPU wins the first conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= PORT_D;
    else      last_q <= last_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU port (c) and a debug/DMA
// port (d). Registered command stage, registered read return, plus a clear
// engine that zero-fills every word one per clock.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start,
  output logic          clr_busy,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int            CW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [CW-1:0] CLR_END = CW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic          cmd_we_q, cmd_we_d;
  logic          cmd_port_q, cmd_port_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic          c_rvalid_q, c_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;

  logic          grant_ok, cmd_in_range;
  logic [1:0]    arb_gnt, gnt;
  logic [DW-1:0] rd_val;

  // Grants are suppressed in reset, while clearing and when a clear is requested.
  assign grant_ok     = rst && (state_q != ST_CLEAR) && !clr_start;
  assign gnt          = arb_gnt & {2{grant_ok}};
  assign c_gnt        = gnt[0];
  assign d_gnt        = gnt[1];
  assign cmd_in_range = cmd_addr_q < DEPTH_A;
  assign rd_val       = cmd_in_range ? mem_rd : '0;
  assign clr_busy     = (state_q == ST_CLEAR);
  assign c_rvalid     = c_rvalid_q;
  assign c_rdata      = c_rdata_q;
  assign d_rvalid     = d_rvalid_q;
  assign d_rdata      = d_rdata_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({d_req, c_req}),
    .advance (grant_ok),
    .gnt     (arb_gnt)
  );

  // Next state, command latch, clear counter and memory-side drive.
  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    cmd_port_d  = cmd_port_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    clr_cnt_d   = clr_cnt_q;
    mem_we      = 1'b0;
    mem_a       = '0;
    mem_wd      = '0;
    case (state_q)
      ST_ACCESS: begin
        mem_we = cmd_we_q && cmd_in_range;
        mem_a  = cmd_addr_q;
        mem_wd = cmd_wdata_q;
      end
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_a  = AW'(clr_cnt_q);
        if (clr_cnt_q == CLR_END) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    // Outside CLEAR a clear request beats any pending command.
    if (state_q != ST_CLEAR) begin
      if (clr_start) begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end else if (|gnt) begin
        state_d     = ST_ACCESS;
        cmd_port_d  = gnt[1];
        cmd_we_d    = gnt[1] ? d_we    : c_we;
        cmd_addr_d  = gnt[1] ? d_addr  : c_addr;
        cmd_wdata_d = gnt[1] ? d_wdata : c_wdata;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Read return: capture memory data at the end of a read ACCESS cycle.
  always_comb begin
    c_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    c_rdata_d  = c_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (state_q == ST_ACCESS && !cmd_we_q) begin
      if (cmd_port_q == PORT_D) begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = rd_val;
      end else begin
        c_rvalid_d = 1'b1;
        c_rdata_d  = rd_val;
      end
    end
  end

  // State, command and return registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cmd_we_q    <= 1'b0;
      cmd_port_q  <= PORT_C;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      clr_cnt_q   <= '0;
      c_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      cmd_port_q  <= cmd_port_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      clr_cnt_q   <= clr_cnt_d;
      c_rvalid_q  <= c_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      c_rdata_q   <= c_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a stand-in 8x8 data memory, a transaction-level
// reference model checked every cycle, and directed scenarios with literal checks.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr_start = 1'b0;
  logic       clr_busy;
  logic       c_req = 1'b0, c_we = 1'b0, c_gnt, c_rvalid;
  logic [7:0] c_addr = 8'h00, c_wdata = 8'h00, c_rdata;
  logic       d_req = 1'b0, d_we = 1'b0, d_gnt, d_rvalid;
  logic [7:0] d_addr = 8'h00, d_wdata = 8'h00, d_rdata;
  logic       mem_we;
  logic [7:0] mem_a, mem_wd, mem_rd;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(8), .DW(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // DATA_MEMORY stand-in: word 0 reads as zero, reset with the same rst.
  logic [7:0] mem [8];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
    end else if (mem_we && mem_a < 8'd8 && mem_a != 8'd0) begin
      mem[mem_a[2:0]] <= mem_wd;
    end
  end
  assign mem_rd = (mem_a < 8'd8) ? mem[mem_a[2:0]] : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model state: what executes this cycle, what returns this cycle.
  int         busy_left, clr_idx;
  bit         last_d_won;
  bit         acc_v, acc_p, acc_we;
  logic [7:0] acc_a, acc_wd;
  bit         ret_v, ret_p;
  logic [7:0] ret_d;
  logic [7:0] ref_mem [8];
  bit         m_ok, m_gc, m_gd, m_we, m_start;

  // Compare every cycle, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_c_gnt", c_gnt, 0);   chk("rst_d_gnt", d_gnt, 0);
      chk("rst_c_rvalid", c_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_c_rdata", c_rdata, 0);   chk("rst_d_rdata", d_rdata, 0);
      chk("rst_mem_we", mem_we, 0);     chk("rst_clr_busy", clr_busy, 0);
      busy_left = 0; clr_idx = 0; last_d_won = 1'b1;
      acc_v = 1'b0; ret_v = 1'b0;
      for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    end else begin
      m_ok = (busy_left == 0) && !clr_start;
      m_gc = m_ok && c_req && (!d_req || last_d_won);
      m_gd = m_ok && d_req && (!c_req || !last_d_won);
      m_we = (busy_left > 0) ? 1'b1 : (acc_v && acc_we && acc_a < 8'd8);
      chk("m_clr_busy", clr_busy, busy_left > 0);
      chk("m_c_gnt", c_gnt, m_gc);
      chk("m_d_gnt", d_gnt, m_gd);
      chk("m_mem_we", mem_we, m_we);
      if (m_we) begin
        chk("m_mem_a", mem_a, (busy_left > 0) ? clr_idx : acc_a);
        chk("m_mem_wd", mem_wd, (busy_left > 0) ? 8'h00 : acc_wd);
      end
      chk("m_c_rvalid", c_rvalid, ret_v && !ret_p);
      chk("m_d_rvalid", d_rvalid, ret_v && ret_p);
      if (ret_v) chk("m_rdata", ret_p ? d_rdata : c_rdata, ret_d);
      ret_v = acc_v && !acc_we;
      ret_p = acc_p;
      ret_d = (acc_a < 8'd8) ? ref_mem[acc_a[2:0]] : 8'h00;
      if (acc_v && acc_we && acc_a < 8'd8 && acc_a != 8'd0) ref_mem[acc_a[2:0]] = acc_wd;
      m_start = (busy_left == 0) && clr_start;
      if (busy_left > 0) begin
        ref_mem[clr_idx] = 8'h00;
        clr_idx++;
        busy_left--;
      end
      acc_v  = m_gc || m_gd;
      acc_p  = m_gd;
      acc_we = m_gd ? d_we : c_we;
      acc_a  = m_gd ? d_addr : c_addr;
      acc_wd = m_gd ? d_wdata : c_wdata;
      if (m_gc || m_gd) last_d_won = m_gd;
      if (m_start) begin busy_left = 8; clr_idx = 0; end
    end
  end

  // Present a command on port p, hold until granted; returns in the ACCESS cycle.
  task automatic do_cmd(input bit p, input bit we, input logic [7:0] a, input logic [7:0] wd,
                        output int waited);
    @(posedge clk); #1;
    if (p) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
    else   begin c_req = 1; c_we = we; c_addr = a; c_wdata = wd; end
    waited = 0;
    while (waited < 20) begin
      @(negedge clk);
      if ((p ? d_gnt : c_gnt) === 1'b1) break;
      waited++;
    end
    if (waited >= 20) chk("gnt_timeout", 0, 1);
    @(posedge clk); #1;
    if (p) d_req = 0; else c_req = 0;
  endtask

  // Read and check latency (2 negedges after accept) and data.
  task automatic do_read(input bit p, input logic [7:0] a, input logic [7:0] exp);
    int w, n;
    do_cmd(p, 1'b0, a, 8'h00, w);
    n = 0;
    while (n < 6) begin
      @(negedge clk); n++;
      if ((p ? d_rvalid : c_rvalid) === 1'b1) break;
    end
    chk("rd_latency", n, 2);
    chk("rd_data", p ? d_rdata : c_rdata, exp);
  endtask

  logic [1:0] seq [6];
  int w, n;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk); #1;
    chk("reset_clr_busy", clr_busy, 0);
    chk("reset_mem_a", mem_a, 0);
    chk("reset_c_rdata", c_rdata, 0);
    @(posedge clk); #1 rst = 1;

    // Both ports read every cycle: CPU wins first, then strict alternation.
    c_req = 1; d_req = 1; c_we = 0; d_we = 0; c_addr = 8'd2; d_addr = 8'd5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seq[i] = {d_gnt, c_gnt};
    end
    @(posedge clk); #1 c_req = 0; d_req = 0;
    for (int i = 0; i < 6; i++) chk("alt_gnt", seq[i], (i % 2) ? 2'b10 : 2'b01);
    repeat (3) @(posedge clk);

    // CPU write then read back.
    do_cmd(0, 1, 8'd3, 8'h5A, w);
    chk("wr_gnt_same_cycle", w, 0);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_a", mem_a, 3);
    do_read(0, 8'd3, 8'h5A);

    // Word 0 stays zero; out-of-range write dropped, read returns zero.
    do_cmd(1, 1, 8'd0, 8'hFF, w);
    do_read(1, 8'd0, 8'h00);
    do_cmd(1, 1, 8'd9, 8'hAB, w);
    chk("oor_mem_we", mem_we, 0);
    do_read(1, 8'd9, 8'h00);

    // Fill, then a clear arriving behind an in-flight read.
    for (int a = 1; a < 8; a++) do_cmd(0, 1, 8'(a), 8'(a), w);
    do_cmd(0, 0, 8'd5, 8'h00, w);
    clr_start = 1;
    @(posedge clk); #1 clr_start = 0;
    c_req = 1; c_we = 0; c_addr = 8'd1;
    @(negedge clk);
    chk("clr_inflight_rvalid", c_rvalid, 1);
    chk("clr_inflight_rdata", c_rdata, 8'h05);
    chk("clr_busy_first", clr_busy, 1);
    n = clr_busy ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!clr_busy) break;
      n++;
      chk("clr_no_gnt", c_gnt, 0);
    end
    chk("clr_busy_cycles", n, 8);
    chk("post_clr_gnt", c_gnt, 1);
    @(posedge clk); #1 c_req = 0;
    repeat (3) @(posedge clk);
    for (int a = 0; a < 8; a++) do_read(0, 8'(a), 8'h00);

    // Reset in the middle of a clear (counter = 4).
    do_cmd(0, 1, 8'd4, 8'h44, w);
    @(posedge clk); #1 clr_start = 1;
    @(posedge clk); #1 clr_start = 0;
    repeat (4) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("rstmid_clr_busy", clr_busy, 0);
    chk("rstmid_mem_we", mem_we, 0);
    chk("rstmid_c_rvalid", c_rvalid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    do_read(1, 8'd4, 8'h00);
    do_cmd(0, 1, 8'd6, 8'h66, w);
    chk("resume_gnt", w, 0);
    do_read(0, 8'd6, 8'h66);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
